l2_write_buffer: RTL

Single-entry write-back buffer between the cache arbiter and the L2 cache. It absorbs cacheline writebacks from the arbiter and acknowledges them in one cycle. It drains the buffered line to L2 when the L2 port is otherwise idle. Reads pass through to L2, except a read that hits the buffered line is served from the buffer without an L2 access.

---
 rtl/l2_write_buffer_pkg.sv | 9 +
 rtl/l2_write_buffer_control.sv | 83 ++++++++
 rtl/l2_write_buffer.sv | 72 +++++++
 3 files changed

// File: rtl/l2_write_buffer_pkg.sv
// Shared LC-3b memory types plus the line geometry used by the L2 write buffer.
package l2_write_buffer_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cacheline;

   localparam int unsigned LC3B_LINE_OFFSET_BITS = 4;

endpackage

// File: rtl/l2_write_buffer_control.sv
// Control FSM for the single-entry L2 write buffer: sequences acks, read pass-through and drains.
module l2_write_buffer_control (
   input  logic clk,
   input  logic rst,
   input  logic read_i,
   input  logic write_i,
   input  logic match_i,
   input  logic buf_valid_i,
   input  logic l2_resp_i,
   output logic load_buf_o,
   output logic load_rdata_o,
   output logic clr_valid_o,
   output logic sel_read_o,
   output logic l2_read_o,
   output logic l2_write_o,
   output logic resp_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRESP,
      S_HRESP,
      S_READ,
      S_DRAIN
   } state_t;

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Reads beat writes and beat draining; a started drain or read runs to its L2 response.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (read_i) begin
               if (match_i) state_d = S_HRESP;
               else         state_d = S_READ;
            end else if (write_i) begin
               if (!buf_valid_i || match_i) state_d = S_WRESP;
               else                         state_d = S_DRAIN;
            end else if (buf_valid_i) begin
               state_d = S_DRAIN;
            end
         end
         S_WRESP, S_HRESP: state_d = S_IDLE;
         S_READ:  if (l2_resp_i) state_d = S_IDLE;
         S_DRAIN: if (l2_resp_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_buf_o   = 1'b0;
      load_rdata_o = 1'b0;
      clr_valid_o  = 1'b0;
      sel_read_o   = 1'b0;
      l2_read_o    = 1'b0;
      l2_write_o   = 1'b0;
      resp_o       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            load_rdata_o = read_i && match_i;
            load_buf_o   = !read_i && write_i && (!buf_valid_i || match_i);
         end
         S_WRESP, S_HRESP: resp_o = 1'b1;
         S_READ: begin
            sel_read_o = 1'b1;
            l2_read_o  = 1'b1;
            resp_o     = l2_resp_i;
         end
         S_DRAIN: begin
            l2_write_o  = 1'b1;
            clr_valid_o = l2_resp_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/l2_write_buffer.sv
// Single-entry write-back buffer between the cache arbiter and L2: buffer registers,
// line-match comparator and output muxing around the control FSM.
module l2_write_buffer
   import l2_write_buffer_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  arb_address_in,
   input  logic [127:0] arb_wdata_in,
   input  logic         arb_read_in,
   input  logic         arb_write_in,
   output logic [127:0] arb_rdata_out,
   output logic         arb_resp_out,
   output logic [15:0]  l2_address_out,
   output logic [127:0] l2_wdata_out,
   output logic         l2_read_out,
   output logic         l2_write_out,
   input  logic [127:0] l2_rdata_in,
   input  logic         l2_resp_in
);

   lc3b_word      buf_addr_q;
   lc3b_cacheline buf_data_q;
   lc3b_cacheline rdata_q;
   logic          buf_valid_q;

   logic match;
   logic load_buf, load_rdata, clr_valid, sel_read;

   assign match = buf_valid_q &&
                  (arb_address_in[15:LC3B_LINE_OFFSET_BITS] == buf_addr_q[15:LC3B_LINE_OFFSET_BITS]);

   l2_write_buffer_control u_control (
      .clk          (clk),
      .rst          (rst),
      .read_i       (arb_read_in),
      .write_i      (arb_write_in),
      .match_i      (match),
      .buf_valid_i  (buf_valid_q),
      .l2_resp_i    (l2_resp_in),
      .load_buf_o   (load_buf),
      .load_rdata_o (load_rdata),
      .clr_valid_o  (clr_valid),
      .sel_read_o   (sel_read),
      .l2_read_o    (l2_read_out),
      .l2_write_o   (l2_write_out),
      .resp_o       (arb_resp_out)
   );

   // The stored address is line-aligned so a coalescing write keeps the original line address.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         rdata_q     <= '0;
      end else begin
         if (load_buf) begin
            buf_addr_q <= {arb_address_in[15:LC3B_LINE_OFFSET_BITS], {LC3B_LINE_OFFSET_BITS{1'b0}}};
            buf_data_q <= arb_wdata_in;
         end
         if (load_buf)       buf_valid_q <= 1'b1;
         else if (clr_valid) buf_valid_q <= 1'b0;
         if (load_rdata)     rdata_q <= buf_data_q;
      end
   end

   assign l2_address_out = sel_read ? arb_address_in : buf_addr_q;
   assign l2_wdata_out   = buf_data_q;
   assign arb_rdata_out  = sel_read ? l2_rdata_in : rdata_q;

endmodule
